// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, ACK/NACK bit levels and default target address
// for the I2C target (i2c_slave) and its helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK
    } i2c_state_e;

    localparam logic       ACK                = 1'b0;
    localparam logic       NACK               = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: two-flop synchronizer for one raw bus line; RESET_VAL is the level
// presented while reset is asserted (idle bus = 1).
module i2c_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit address I2C target bridging bus writes/reads to external RX/TX FIFOs.
// Define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL on TX-empty / RX-full instead of 0xFF / NACK.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       clk,
    input  logic       i2c_reset_n,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_scl_oe,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       fifo_rx_wr_en,
    input  logic       fifo_rx_full,
    input  logic [7:0] tx_data,
    output logic       fifo_tx_rd_en,
    input  logic       fifo_tx_empty,
    output logic       busy
);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    localparam logic STRETCH_EN = 1'b1;
`else
    localparam logic STRETCH_EN = 1'b0;
`endif

    logic       scl_s, sda_s;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       done_q, done_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       load_q, load_d;
    logic       pop_pend_q, pop_pend_d;
    logic       wr_pend_q, wr_pend_d;
    logic       stretch_q, stretch_d;
    logic       sda_oe_q, sda_oe_d;
    logic       scl_oe_q, scl_oe_d;
    logic       busy_q, busy_d;
    logic       rd_en_q, rd_en_d;
    logic       wr_en_q, wr_en_d;
    logic       scl_rise, scl_fall, start_det, stop_det, tx_req;
    logic [7:0] rx_byte;

    i2c_sync #(.RESET_VAL(1'b1)) u_sync_scl (
        .clk   (clk),
        .rst_n (i2c_reset_n),
        .d_in  (i2c_scl_in),
        .q_out (scl_s)
    );

    i2c_sync #(.RESET_VAL(1'b1)) u_sync_sda (
        .clk   (clk),
        .rst_n (i2c_reset_n),
        .d_in  (i2c_sda_in),
        .q_out (sda_s)
    );

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        done_d     = done_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        load_d     = rd_en_q;
        pop_pend_d = pop_pend_q;
        wr_pend_d  = wr_pend_q;
        stretch_d  = stretch_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        busy_d     = busy_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        tx_req     = 1'b0;

        // FIFO data is valid the clock after the pop strobe, so load one clock later still
        if (load_q) shift_d = tx_data;

        if (start_det || stop_det) begin
            state_d    = start_det ? ST_ADDR : ST_IDLE;
            bit_cnt_d  = 3'd7;
            done_d     = 1'b0;
            pop_pend_d = 1'b0;
            wr_pend_d  = 1'b0;
            stretch_d  = 1'b0;
            sda_oe_d   = 1'b0;
            scl_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd0) done_d = 1'b1;
                        else bit_cnt_d = bit_cnt_q - 3'd1;
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_TX_ACK: begin
                    if (stretch_q) begin
                        if (pop_pend_q && !fifo_tx_empty) begin
                            rd_en_d    = 1'b1;
                            pop_pend_d = 1'b0;
                        end
                        if (load_q) begin
                            state_d   = ST_TX;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = ~tx_data[7];
                            scl_oe_d  = 1'b0;
                            stretch_d = 1'b0;
                        end
                    end else if (scl_rise) begin
                        if (state_q == ST_ADDR_ACK) begin
                            tx_req = rw_q;
                        end else if (sda_s == ACK) begin
                            tx_req = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        if (!rw_q) begin
                            state_d   = ST_RX;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = 1'b0;
                        end else if (pop_pend_q) begin
                            scl_oe_d  = 1'b1;
                            stretch_d = 1'b1;
                        end else begin
                            state_d   = ST_TX;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = ~shift_q[7];
                        end
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d  = ST_TX_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                ST_RX: begin
                    if (stretch_q) begin
                        if (!fifo_rx_full) begin
                            wr_en_d   = 1'b1;
                            wr_pend_d = 1'b0;
                            ack_d     = ACK;
                            sda_oe_d  = 1'b1;
                            scl_oe_d  = 1'b0;
                            stretch_d = 1'b0;
                            state_d   = ST_RX_ACK;
                        end
                    end else if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd0) begin
                            done_d    = 1'b1;
                            rx_data_d = rx_byte;
                            if (!fifo_rx_full) begin
                                wr_en_d = 1'b1;
                                ack_d   = ACK;
                            end else if (STRETCH_EN) begin
                                wr_pend_d = 1'b1;
                                ack_d     = ACK;
                            end else begin
                                ack_d = NACK;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (wr_pend_q && fifo_rx_full) begin
                            scl_oe_d  = 1'b1;
                            stretch_d = 1'b1;
                        end else begin
                            if (wr_pend_q) begin
                                wr_en_d   = 1'b1;
                                wr_pend_d = 1'b0;
                            end
                            state_d  = ST_RX_ACK;
                            sda_oe_d = (ack_q == ACK);
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (ack_q == ACK) begin
                            state_d   = ST_RX;
                            bit_cnt_d = 3'd7;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (tx_req) begin
            if (!fifo_tx_empty)  rd_en_d    = 1'b1;
            else if (STRETCH_EN) pop_pend_d = 1'b1;
            else                 shift_d    = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= ACK;
            load_q     <= 1'b0;
            pop_pend_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            stretch_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            load_q     <= load_d;
            pop_pend_q <= pop_pend_d;
            wr_pend_q  <= wr_pend_d;
            stretch_q  <= stretch_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign i2c_scl_oe    = scl_oe_q;
    assign i2c_sda_oe    = sda_oe_q;
    assign rx_data       = rx_data_q;
    assign fifo_rx_wr_en = wr_en_q;
    assign fifo_tx_rd_en = rd_en_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bench for i2c_slave with an open-drain master model and
// simple TX/RX FIFO models; expected values are hand-computed per step.
module tb_i2c_slave;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       i2c_reset_n;
    logic       scl_m, sda_m;
    logic       scl_bus, sda_bus;
    logic       i2c_scl_oe, i2c_sda_oe;
    logic [7:0] rx_data;
    logic       fifo_rx_wr_en;
    logic       fifo_rx_full;
    logic [7:0] tx_data = 8'h00;
    logic       fifo_tx_rd_en;
    logic       fifo_tx_empty;
    logic       busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    assign scl_bus = scl_m & ~i2c_scl_oe;
    assign sda_bus = sda_m & ~i2c_sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk           (clk),
        .i2c_reset_n   (i2c_reset_n),
        .i2c_scl_in    (scl_bus),
        .i2c_sda_in    (sda_bus),
        .i2c_scl_oe    (i2c_scl_oe),
        .i2c_sda_oe    (i2c_sda_oe),
        .rx_data       (rx_data),
        .fifo_rx_wr_en (fifo_rx_wr_en),
        .fifo_rx_full  (fifo_rx_full),
        .tx_data       (tx_data),
        .fifo_tx_rd_en (fifo_tx_rd_en),
        .fifo_tx_empty (fifo_tx_empty),
        .busy          (busy)
    );

    logic [7:0]  tx_mem [0:63];
    int unsigned tx_rd = 0;
    int unsigned tx_wr = 0;
    assign fifo_tx_empty = (tx_rd == tx_wr);

    int unsigned wr_cnt = 0, rd_cnt = 0, sda_oe_cyc = 0, scl_oe_cyc = 0;
    logic [7:0]  rx_log [$];

    always @(posedge clk) begin
        if (fifo_tx_rd_en) begin
            tx_data <= tx_mem[tx_rd[5:0]];
            tx_rd   <= tx_rd + 1;
            rd_cnt  <= rd_cnt + 1;
        end
        if (fifo_rx_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            rx_log.push_back(rx_data);
        end
        if (i2c_sda_oe) sda_oe_cyc <= sda_oe_cyc + 1;
        if (i2c_scl_oe) scl_oe_cyc <= scl_oe_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scl_high();
        int unsigned n = 0;
        while (scl_bus !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("scl_release", 32'(scl_bus), 32'd1);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        #50;
        scl_m = 1'b1;
        wait_scl_high();
        #50;
        s = sda_bus;
        #50;
        scl_m = 1'b0;
        #50;
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        #50;
        scl_m = 1'b1;
        wait_scl_high();
        #50;
        sda_m = 1'b0;
        #50;
        scl_m = 1'b0;
        #50;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        #50;
        scl_m = 1'b1;
        wait_scl_high();
        #50;
        sda_m = 1'b1;
        #50;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(mack, s);
    endtask

    initial begin
        logic        ack;
        logic [7:0]  d;
        int unsigned wr_base, rd_base, oe_base, scl_base, log_base;

        i2c_reset_n  = 1'b0;
        scl_m        = 1'b1;
        sda_m        = 1'b1;
        fifo_rx_full = 1'b0;
        #23;
        check("rst_sda_oe", 32'(i2c_sda_oe), 32'd0);
        check("rst_scl_oe", 32'(i2c_scl_oe), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_wr_en",  32'(fifo_rx_wr_en), 32'd0);
        check("rst_rd_en",  32'(fifo_tx_rd_en), 32'd0);
        check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
        i2c_reset_n = 1'b1;
        #100;
        scl_base = scl_oe_cyc;

        // write 0x50+W, 0xA5, 0x3C
        wr_base = wr_cnt; log_base = rx_log.size();
        start_cond();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'(ACK));
        check("wr_busy", 32'(busy), 32'd1);
        write_byte(8'hA5, ack);
        check("wr_b0_ack", 32'(ack), 32'(ACK));
        write_byte(8'h3C, ack);
        check("wr_b1_ack", 32'(ack), 32'(ACK));
        stop_cond();
        check("wr_strobes", wr_cnt - wr_base, 32'd2);
        check("wr_rx0", 32'(rx_log[log_base]), 32'hA5);
        check("wr_rx1", 32'(rx_log[log_base + 1]), 32'h3C);
        check("wr_rx_data", 32'(rx_data), 32'h3C);
        check("wr_busy_stop", 32'(busy), 32'd0);
        check("wr_state", 32'(dut.state_q), 32'(ST_IDLE));

        // address 0x51+W: ignored
        wr_base = wr_cnt; oe_base = sda_oe_cyc;
        start_cond();
        write_byte(8'hA2, ack);
        check("bad_addr_nack", 32'(ack), 32'(NACK));
        check("bad_busy", 32'(busy), 32'd0);
        stop_cond();
        check("bad_sda_oe", sda_oe_cyc - oe_base, 32'd0);
        check("bad_strobes", wr_cnt - wr_base, 32'd0);

        // read 0x50+R, FIFO 0x81, 0x7E, master ACK then NACK
        rd_base = rd_cnt;
        tx_mem[tx_wr[5:0]] = 8'h81;
        tx_mem[(tx_wr + 1) % 64] = 8'h7E;
        tx_wr = tx_wr + 2;
        start_cond();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'(ACK));
        read_byte(ACK, d);
        check("rd_b0", 32'(d), 32'h81);
        read_byte(NACK, d);
        check("rd_b1", 32'(d), 32'h7E);
        check("rd_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rd_busy", 32'(busy), 32'd0);
        stop_cond();
        check("rd_pops", rd_cnt - rd_base, 32'd2);

        // read with empty TX FIFO
        rd_base = rd_cnt; scl_base = scl_oe_cyc;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        fork
            begin
                #4000;
                tx_mem[tx_wr[5:0]] = 8'h5A;
                tx_wr = tx_wr + 1;
            end
        join_none
`endif
        start_cond();
        write_byte(8'hA1, ack);
        check("empty_addr_ack", 32'(ack), 32'(ACK));
        read_byte(NACK, d);
        stop_cond();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        check("empty_data", 32'(d), 32'h5A);
        check("empty_pops", rd_cnt - rd_base, 32'd1);
        check("empty_stretched", 32'(scl_oe_cyc != scl_base), 32'd1);
`else
        check("empty_data", 32'(d), 32'hFF);
        check("empty_pops", rd_cnt - rd_base, 32'd0);
        check("empty_no_stretch", scl_oe_cyc - scl_base, 32'd0);
`endif

        // write with RX FIFO full
        wr_base = wr_cnt; log_base = rx_log.size(); scl_base = scl_oe_cyc;
        fifo_rx_full = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        fork
            begin
                #6000;
                fifo_rx_full = 1'b0;
            end
        join_none
`endif
        start_cond();
        write_byte(8'hA0, ack);
        check("full_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h11, ack);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        check("full_data_ack", 32'(ack), 32'(ACK));
        check("full_strobes", wr_cnt - wr_base, 32'd1);
        check("full_rx", 32'(rx_log[log_base]), 32'h11);
        check("full_stretched", 32'(scl_oe_cyc != scl_base), 32'd1);
`else
        check("full_data_nack", 32'(ack), 32'(NACK));
        check("full_strobes", wr_cnt - wr_base, 32'd0);
        check("full_busy", 32'(busy), 32'd0);
`endif
        stop_cond();
        fifo_rx_full = 1'b0;

        // repeated START in the middle of a data byte
        wr_base = wr_cnt; log_base = rx_log.size();
        start_cond();
        write_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
        start_cond();
        check("rs_state", 32'(dut.state_q), 32'(ST_ADDR));
        write_byte(8'hA0, ack);
        check("rs_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h42, ack);
        check("rs_data_ack", 32'(ack), 32'(ACK));
        stop_cond();
        check("rs_strobes", wr_cnt - wr_base, 32'd1);
        check("rs_rx", 32'(rx_log[log_base]), 32'h42);

        // reset pulse while the slave is driving a 0 bit of a read
        rd_base = rd_cnt; wr_base = wr_cnt;
        tx_mem[tx_wr[5:0]] = 8'h81;
        tx_mem[(tx_wr + 1) % 64] = 8'h7E;
        tx_wr = tx_wr + 2;
        start_cond();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, ack);
        check("mid_sda_oe", 32'(i2c_sda_oe), 32'd1);
        i2c_reset_n = 1'b0;
        #1;
        check("mid_rst_sda_oe", 32'(i2c_sda_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        #29;
        i2c_reset_n = 1'b1;
        oe_base = sda_oe_cyc;
        for (int i = 0; i < 5; i++) clk_bit(1'b1, ack);
        clk_bit(NACK, ack);
        stop_cond();
        check("mid_pops", rd_cnt - rd_base, 32'd1);
        check("mid_no_drive", sda_oe_cyc - oe_base, 32'd0);
        check("mid_no_wr", wr_cnt - wr_base, 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        tx_wr = tx_rd;

`ifndef I2C_SLAVE_CLK_STRETCH_EN
        check("scl_oe_never", 32'(scl_oe_cyc), 32'd0);
`endif

        #100;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
